mem_tag_responder: RTL and testbench

MEM_TAG_RESPONDER -- requirements
Module: mem_tag_responder

---
 rtl/sys_defs.sv | 18 +
 rtl/mem_tag_pool.sv | 34 +++
 rtl/mem_tag_responder.sv | 56 +++++
 tb/tb_mem_tag_responder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// sys_defs: shared bus command encoding, memory timing default and response pipeline entry.
package sys_defs;
   typedef enum logic [1:0] {
      BUS_NONE  = 2'd0,
      BUS_LOAD  = 2'd1,
      BUS_STORE = 2'd2
   } BUS_COMMAND;
   localparam int MEM_LATENCY_DEFAULT = 4;
   typedef struct packed {
      logic        valid;
      logic [3:0]  tag;
      logic [63:0] data;
   } MEM_RSP_ENTRY;
   // Tags live in 1..15; 0 is reserved for "no tag".
   function automatic logic [3:0] next_tag(input logic [3:0] t);
      return t == 4'd15 ? 4'd1 : t + 4'd1;
   endfunction
endpackage

// File: rtl/mem_tag_pool.sv
// mem_tag_pool: free-tag bitmap with round-robin allocation of tags 1..15.
module mem_tag_pool
   import sys_defs::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       alloc,
   input  logic [3:0] retire,
   output logic [3:0] grant
);
   logic [15:0] free;
   logic [3:0]  ptr;
   logic [4:0]  c;
   // Descending scan so the smallest offset from the pointer wins.
   always_comb begin
      grant = 4'd0;
      c = 5'd0;
      for (int i = 14; i >= 0; i--) begin
         c = 5'(ptr) + 5'(i);
         c = c > 5'd15 ? c - 5'd15 : c;
         if (free[c[3:0]]) grant = c[3:0];
      end
   end
   // Retired tags return only after this edge, so they are never reissued in their completion cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         free <= 16'hFFFE;
         ptr  <= 4'd1;
      end else begin
         free <= ((free & ~(alloc ? 16'd1 << grant : 16'd0)) | (16'd1 << retire)) & 16'hFFFE;
         if (alloc) ptr <= next_tag(grant);
      end
   end
endmodule

// File: rtl/mem_tag_responder.sv
// mem_tag_responder: tagged memory model returning loads/stores after a fixed latency, in order.
module mem_tag_responder
   import sys_defs::*;
#(
   parameter int MEM_LATENCY    = MEM_LATENCY_DEFAULT,
   parameter int MEM_ADDR_WORDS = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  proc2mem_command,
   input  logic [31:0] proc2mem_addr,
   input  logic [63:0] proc2mem_data,
   output logic [3:0]  mem2proc_response,
   output logic [63:0] mem2proc_data,
   output logic [3:0]  mem2proc_tag
);
   localparam int AW = $clog2(MEM_ADDR_WORDS);
   logic [63:0]  mem [MEM_ADDR_WORDS];
   MEM_RSP_ENTRY pipe [MEM_LATENCY];
   logic [3:0]   grant;
   logic [3:0]   retire;
   logic         is_load;
   logic         is_store;
   logic         accept;
   logic [AW-1:0] idx;
   logic         unused_addr;
   assign unused_addr = ^proc2mem_addr[2:0];
   assign is_load  = proc2mem_command == BUS_LOAD;
   assign is_store = proc2mem_command == BUS_STORE;
   assign idx      = proc2mem_addr[3 +: AW];
   assign accept   = !reset && (is_load || is_store) && grant != 4'd0
                     && proc2mem_addr[31:3] < 29'(MEM_ADDR_WORDS);
   assign mem2proc_response = accept ? grant : 4'd0;
   // The last pipeline stage is the output register; idle entries are all-zero.
   assign mem2proc_tag  = pipe[MEM_LATENCY-1].tag;
   assign mem2proc_data = pipe[MEM_LATENCY-1].data;
   assign retire = pipe[MEM_LATENCY-1].valid ? pipe[MEM_LATENCY-1].tag : 4'd0;
   mem_tag_pool pool (
      .clock (clock),
      .reset (reset),
      .alloc (accept),
      .retire(retire),
      .grant (grant)
   );
   always_ff @(posedge clock) begin
      if (accept && is_store) mem[idx] <= proc2mem_data;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < MEM_LATENCY; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= accept ? MEM_RSP_ENTRY'{valid: 1'b1, tag: grant, data: is_load ? mem[idx] : 64'd0} : '0;
         for (int i = 1; i < MEM_LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end
endmodule

// File: tb/tb_mem_tag_responder.sv
// tb_mem_tag_responder: directed checks of tag allocation, latency, ordering, range and reset flush.
module tb_mem_tag_responder;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  cmd = 2'd0;
   logic [31:0] addr = 32'd0;
   logic [63:0] wdata = 64'd0;
   logic [3:0]  resp, tag, resp14, tag14;
   logic [63:0] data, data14;
   int checks = 0;
   int errors = 0;
   localparam logic [63:0] D = 64'h1122334455667788;

   always #5 clock = ~clock;

   mem_tag_responder dut (
      .clock(clock), .reset(reset), .proc2mem_command(cmd), .proc2mem_addr(addr),
      .proc2mem_data(wdata), .mem2proc_response(resp), .mem2proc_data(data), .mem2proc_tag(tag)
   );
   mem_tag_responder #(.MEM_LATENCY(14)) dut14 (
      .clock(clock), .reset(reset), .proc2mem_command(cmd), .proc2mem_addr(addr),
      .proc2mem_data(wdata), .mem2proc_response(resp14), .mem2proc_data(data14), .mem2proc_tag(tag14)
   );

   // Inputs change mid-cycle; outputs sampled 1 time unit later belong to the same cycle.
   task automatic drive(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d);
      @(negedge clock);
      cmd = c;
      addr = a;
      wdata = d;
      #1;
   endtask

   task automatic test_reset;
      @(negedge clock);
      reset = 1'b1;
      cmd = 2'd1;
      addr = 32'd0;
      #1;
      checks++;
      if (resp !== 4'd0) begin errors++; $display("FAIL reset_response got %0d want 0", resp); end
      @(negedge clock);
      reset = 1'b0;
      cmd = 2'd0;
      #1;
      checks++;
      if (tag !== 4'd0 || data !== 64'd0) begin
         errors++;
         $display("FAIL reset_outputs got tag %0d data %h want 0 0", tag, data);
      end
   endtask

   task automatic test_store_load;
      test_reset();
      drive(2'd2, 32'h40, D);
      checks++;
      if (resp !== 4'd1) begin errors++; $display("FAIL store_response got %0d want 1", resp); end
      drive(2'd1, 32'h44, 64'd0);
      checks++;
      if (resp !== 4'd2) begin errors++; $display("FAIL load_response got %0d want 2", resp); end
      for (int t = 2; t <= 6; t++) begin
         drive(2'd0, 32'd0, 64'd0);
         checks++;
         if (tag !== (t == 4 ? 4'd1 : t == 5 ? 4'd2 : 4'd0) || data !== (t == 5 ? D : 64'd0)) begin
            errors++;
            $display("FAIL store_load_T%0d got tag %0d data %h", t, tag, data);
         end
      end
   endtask

   task automatic test_back_to_back;
      test_reset();
      for (int i = 0; i < 25; i++) begin
         drive(i < 20 ? 2'd1 : 2'd0, 32'(i * 8), 64'd0);
         checks++;
         if (resp !== (i < 20 ? 4'((i % 15) + 1) : 4'd0)) begin
            errors++;
            $display("FAIL b2b_response cycle %0d got %0d want %0d", i, resp, i < 20 ? (i % 15) + 1 : 0);
         end
         checks++;
         if (tag !== (i >= 4 && i < 24 ? 4'(((i - 4) % 15) + 1) : 4'd0)) begin
            errors++;
            $display("FAIL b2b_tag cycle %0d got %0d", i, tag);
         end
      end
   endtask

   task automatic test_out_of_range;
      test_reset();
      drive(2'd1, 32'h2000, 64'd0);
      checks++;
      if (resp !== 4'd0) begin errors++; $display("FAIL range_response got %0d want 0", resp); end
      drive(2'd3, 32'h0, 64'd0);
      checks++;
      if (resp !== 4'd0) begin errors++; $display("FAIL cmd3_response got %0d want 0", resp); end
      for (int i = 0; i < 6; i++) begin
         drive(2'd0, 32'd0, 64'd0);
         checks++;
         if (tag !== 4'd0) begin errors++; $display("FAIL range_no_completion got %0d want 0", tag); end
      end
      drive(2'd1, 32'h1FFF, 64'd0);
      checks++;
      if (resp !== 4'd1) begin errors++; $display("FAIL last_word_response got %0d want 1", resp); end
   endtask

   task automatic test_reset_flush;
      test_reset();
      drive(2'd1, 32'h0, 64'd0);
      checks++;
      if (resp !== 4'd1) begin errors++; $display("FAIL flush_first got %0d want 1", resp); end
      drive(2'd1, 32'h8, 64'd0);
      checks++;
      if (resp !== 4'd2) begin errors++; $display("FAIL flush_second got %0d want 2", resp); end
      @(negedge clock);
      reset = 1'b1;
      addr = 32'h10;
      #1;
      checks++;
      if (resp !== 4'd0) begin errors++; $display("FAIL flush_in_reset got %0d want 0", resp); end
      @(negedge clock);
      reset = 1'b0;
      cmd = 2'd0;
      for (int i = 0; i < 8; i++) begin
         drive(2'd0, 32'd0, 64'd0);
         checks++;
         if (tag !== 4'd0) begin errors++; $display("FAIL flush_tag cycle %0d got %0d want 0", i, tag); end
      end
      drive(2'd1, 32'h40, 64'd0);
      checks++;
      if (resp !== 4'd1) begin errors++; $display("FAIL flush_next got %0d want 1", resp); end
      for (int i = 1; i <= 4; i++) drive(2'd0, 32'd0, 64'd0);
      checks++;
      if (tag !== 4'd1 || data !== D) begin
         errors++;
         $display("FAIL flush_ram_kept got tag %0d data %h want 1 %h", tag, data, D);
      end
   endtask

   task automatic test_deep_pool;
      test_reset();
      for (int i = 0; i < 14; i++) begin
         drive(2'd1, 32'(i * 8), 64'd0);
         checks++;
         if (resp14 !== 4'(i + 1) || tag14 !== 4'd0) begin
            errors++;
            $display("FAIL deep_fill cycle %0d got resp %0d tag %0d want %0d 0", i, resp14, tag14, i + 1);
         end
      end
      drive(2'd1, 32'h100, 64'd0);
      checks++;
      if (resp14 !== 4'd15 || tag14 !== 4'd1) begin
         errors++;
         $display("FAIL deep_15th got resp %0d tag %0d want 15 1", resp14, tag14);
      end
      drive(2'd1, 32'h108, 64'd0);
      checks++;
      if (resp14 !== 4'd1 || tag14 !== 4'd2) begin
         errors++;
         $display("FAIL deep_16th got resp %0d tag %0d want 1 2", resp14, tag14);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      test_store_load();
      test_back_to_back();
      test_out_of_range();
      test_reset_flush();
      test_deep_pool();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
